// File: rtl/macc_sequencer.sv
// macc_sequencer
// Control sequencer for one matrix multiply-accumulate pass:
// C[MxN] = A[MxK] * B[KxN].
// It walks (i, j, k) with k innermost, then j, then i. For each iteration it
// issues a registered operand read. The MAC strobes follow through a delay
// pipe matched to the operand-memory read latency.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   start             one-cycle pass request, sampled only in IDLE
//   m_max/n_max/k_max dimension masks M-1, N-1, K-1 (each must be 2^x-1)
//   en                issue enable; low stalls address issue
//   rd_en             operand read strobe (A and B)
//   a_addr, b_addr    A address (i<<lgK)|k, B address (k<<lgN)|j
//   mac_clr, mac_en   MAC load-first-term / accumulate strobes
//   c_wr, c_addr      C write strobe (last k term) and address (i<<lgN)|j
//   busy, done        pass in progress / one-cycle completion pulse
//   cfg_err           one-cycle pulse when a start is rejected
module macc_sequencer #(
    parameter int MSB    = 11,
    parameter int RD_LAT = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [MSB:0] m_max,
    input  logic [MSB:0] n_max,
    input  logic [MSB:0] k_max,
    input  logic         en,
    output logic         rd_en,
    output logic [MSB:0] a_addr,
    output logic [MSB:0] b_addr,
    output logic         mac_clr,
    output logic         mac_en,
    output logic         c_wr,
    output logic [MSB:0] c_addr,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);
    localparam int AW  = MSB + 1;
    localparam int LGW = $clog2(AW + 1);
    localparam logic [LGW:0] ADDR_BITS = AW[LGW:0];
    // Selects every pipe stage except the tail, which empties on the next edge.
    localparam logic [RD_LAT-1:0] HEAD_MASK = {RD_LAT{1'b1}} >> 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic         vld;
        logic         first;
        logic         last;
        logic [MSB:0] caddr;
    } stage_t;

    // Count of contiguous low-order ones.
    function automatic logic [LGW-1:0] trail_ones(input logic [MSB:0] v);
        logic [LGW-1:0] n;
        logic           run;
        n   = '0;
        run = 1'b1;
        for (int b = 0; b < AW; b++) begin
            if (run && v[b]) begin
                n = n + LGW'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic logic is_mask(input logic [MSB:0] v);
        return (v & (v + AW'(1))) == '0;
    endfunction

    state_t         state_q, state_d;
    logic [MSB:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [MSB:0]   m_max_q, m_max_d, n_max_q, n_max_d, k_max_q, k_max_d;
    logic [LGW-1:0] lg_n_q, lg_n_d, lg_k_q, lg_k_d;
    logic [MSB:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    stage_t         iss_q, iss_d;
    logic           cfg_err_q, cfg_err_d;

    logic [LGW-1:0] lg_m_in, lg_n_in, lg_k_in;
    logic [LGW:0]   sum_mk, sum_kn, sum_mn;
    logic           cfg_ok;
    logic           last_iter;
    logic           pipe_pending;
    logic [RD_LAT-1:0] pipe_vld;
    stage_t         pipe_tail;

    // Configuration decode of the live inputs (used only when start is taken).
    always_comb begin
        lg_m_in = trail_ones(m_max);
        lg_n_in = trail_ones(n_max);
        lg_k_in = trail_ones(k_max);
        sum_mk  = {1'b0, lg_m_in} + {1'b0, lg_k_in};
        sum_kn  = {1'b0, lg_k_in} + {1'b0, lg_n_in};
        sum_mn  = {1'b0, lg_m_in} + {1'b0, lg_n_in};
        cfg_ok  = is_mask(m_max) && is_mask(n_max) && is_mask(k_max) &&
                  (sum_mk <= ADDR_BITS) && (sum_kn <= ADDR_BITS) &&
                  (sum_mn <= ADDR_BITS);
    end

    always_comb begin
        last_iter    = (i_q == m_max_q) && (j_q == n_max_q) && (k_q == k_max_q);
        // Work is still in flight if anything survives the next shift.
        pipe_pending = iss_q.vld | (|(pipe_vld & HEAD_MASK));
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        m_max_d   = m_max_q;
        n_max_d   = n_max_q;
        k_max_d   = k_max_q;
        lg_n_d    = lg_n_q;
        lg_k_d    = lg_k_q;
        a_addr_d  = a_addr_q;
        b_addr_d  = b_addr_q;
        iss_d     = '0;
        cfg_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        m_max_d = m_max;
                        n_max_d = n_max;
                        k_max_d = k_max;
                        lg_n_d  = lg_n_in;
                        lg_k_d  = lg_k_in;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        state_d = S_ISSUE;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (en) begin
                    iss_d.vld   = 1'b1;
                    iss_d.first = (k_q == '0);
                    iss_d.last  = (k_q == k_max_q);
                    iss_d.caddr = (i_q << lg_n_q) | j_q;
                    a_addr_d    = (i_q << lg_k_q) | k_q;
                    b_addr_d    = (k_q << lg_n_q) | j_q;
                    if (k_q == k_max_q) begin
                        k_d = '0;
                        if (j_q == n_max_q) begin
                            j_d = '0;
                            i_d = (i_q == m_max_q) ? '0 : i_q + AW'(1);
                        end else begin
                            j_d = j_q + AW'(1);
                        end
                    end else begin
                        k_d = k_q + AW'(1);
                    end
                    if (last_iter) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!pipe_pending) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            m_max_q   <= '0;
            n_max_q   <= '0;
            k_max_q   <= '0;
            lg_n_q    <= '0;
            lg_k_q    <= '0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            iss_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            m_max_q   <= m_max_d;
            n_max_q   <= n_max_d;
            k_max_q   <= k_max_d;
            lg_n_q    <= lg_n_d;
            lg_k_q    <= lg_k_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            iss_q     <= iss_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Delay pipe fed by the registered issue stage, so the tail lines up with
    // read data RD_LAT cycles after rd_en. It always shifts, ignoring en.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            stage_t stg_q, stg_d;
            if (gi == 0) begin : g_head
                always_comb stg_d = iss_q;
            end else begin : g_body
                always_comb stg_d = g_pipe[gi-1].stg_q;
            end
            always_ff @(posedge CLK) begin
                if (RST) begin
                    stg_q <= '0;
                end else begin
                    stg_q <= stg_d;
                end
            end
            assign pipe_vld[gi] = stg_q.vld;
            if (gi == RD_LAT - 1) begin : g_tail
                assign pipe_tail = stg_q;
            end
        end
    endgenerate

    assign rd_en   = iss_q.vld;
    assign a_addr  = a_addr_q;
    assign b_addr  = b_addr_q;
    assign mac_en  = pipe_tail.vld;
    assign mac_clr = pipe_tail.vld & pipe_tail.first;
    assign c_wr    = pipe_tail.vld & pipe_tail.last;
    assign c_addr  = pipe_tail.caddr;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_macc_sequencer.sv
// Self-checking bench for macc_sequencer. A reference model is built from the
// loop-nest definition of the pass and the issue-enable pattern. The model
// gives the expected beat list, the expected beat timing and the done cycle.
module tb_macc_sequencer;
    localparam int MSB     = 11;
    localparam int RD_LAT  = 2;
    localparam int AW      = MSB + 1;
    localparam int PAT_LEN = 4096;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic         en;
    logic [MSB:0] m_max, n_max, k_max;
    logic         rd_en, mac_clr, mac_en, c_wr, busy, done, cfg_err;
    logic [MSB:0] a_addr, b_addr, c_addr;

    int checks   = 0;
    int failures = 0;
    bit en_pat [PAT_LEN];

    always #5 CLK = ~CLK;

    macc_sequencer #(.MSB(MSB), .RD_LAT(RD_LAT)) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .m_max(m_max), .n_max(n_max), .k_max(k_max), .en(en),
        .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .c_wr(c_wr), .c_addr(c_addr),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [42:0] outs;
        RST = 1'b1; start = 1'b0; en = 1'b0;
        m_max = '0; n_max = '0; k_max = '0;
        tick();
        tick();
        outs = {rd_en, a_addr, b_addr, mac_clr, mac_en, c_wr, c_addr, busy, done, cfg_err};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        RST = 1'b0;
        tick();
        checks++;
        if ({busy, done, cfg_err, rd_en} !== 4'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got %b expected 0000", {busy, done, cfg_err, rd_en});
        end
        $display("test_reset: done");
    endtask

    // One full pass. mode: 0 = en always high, 1 = en high on even cycles
    // only, 2 = random en. mid_start_cyc / start_on_done inject starts that
    // must be ignored. fixed_done >= 0 also checks the done cycle against an
    // absolute value.
    task automatic test_pass(input string name, input int lm, input int ln, input int lk,
                             input int mode, input int mid_start_cyc, input bit start_on_done,
                             input int fixed_done);
        int m_n, n_n, k_n, total, exp_done, budget, done_cyc, done_cnt;
        int exp_iss[$], exp_a[$], exp_b[$], exp_c[$];
        bit exp_f[$], exp_l[$];
        int obs_rd_cyc[$], obs_a[$], obs_b[$], obs_mac_cyc[$], obs_c[$];
        bit obs_clr[$], obs_wr[$];
        bit err_seen, busy_gap, post_bad;
        m_n = 1 << lm; n_n = 1 << ln; k_n = 1 << lk;
        total = m_n * n_n * k_n;
        done_cyc = -1; done_cnt = 0;
        err_seen = 1'b0; busy_gap = 1'b0; post_bad = 1'b0;

        for (int t = 0; t < PAT_LEN; t++) begin
            case (mode)
                0:       en_pat[t] = 1'b1;
                1:       en_pat[t] = (t % 2 == 0);
                default: en_pat[t] = ($urandom_range(0, 3) != 0);
            endcase
        end
        // Cycle 0 carries the start; issue is possible from cycle 1 onward.
        for (int t = 1; t < PAT_LEN && exp_iss.size() < total; t++)
            if (en_pat[t]) exp_iss.push_back(t);
        for (int i = 0; i < m_n; i++)
            for (int j = 0; j < n_n; j++)
                for (int k = 0; k < k_n; k++) begin
                    exp_a.push_back(i * k_n + k);
                    exp_b.push_back(k * n_n + j);
                    exp_c.push_back(i * n_n + j);
                    exp_f.push_back(k == 0);
                    exp_l.push_back(k == k_n - 1);
                end
        // rd_en one cycle after issue, mac RD_LAT later, done the cycle after.
        exp_done = exp_iss[exp_iss.size()-1] + RD_LAT + 2;
        budget   = exp_done + 12;

        m_max = AW'(m_n - 1); n_max = AW'(n_n - 1); k_max = AW'(k_n - 1);
        start = 1'b1;
        en    = en_pat[0];
        tick();
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (rd_en) begin
                obs_rd_cyc.push_back(cyc); obs_a.push_back(int'(a_addr)); obs_b.push_back(int'(b_addr));
            end
            if (mac_en) begin
                obs_mac_cyc.push_back(cyc); obs_clr.push_back(mac_clr);
                obs_wr.push_back(c_wr); obs_c.push_back(int'(c_addr));
            end
            if (cfg_err) err_seen = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc < 0 && !busy) busy_gap = 1'b1;
            if (done_cyc >= 0 && cyc > done_cyc && (busy || rd_en || mac_en)) post_bad = 1'b1;
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
            start = (cyc == mid_start_cyc) || (start_on_done && done);
            en    = (cyc < PAT_LEN) ? en_pat[cyc] : 1'b1;
            if (cyc == 1) begin
                // The pass must run on the latched configuration.
                m_max = AW'($urandom); n_max = AW'($urandom); k_max = AW'($urandom);
            end
            tick();
        end
        start = 1'b0;
        en    = 1'b0;

        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL %s done_timeout: no done within %0d cycles, expected at %0d", name, budget, exp_done);
        end
        checks++;
        if (done_cyc != exp_done) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
        end
        if (fixed_done >= 0) begin
            checks++;
            if (done_cyc != fixed_done) begin
                failures++;
                $display("FAIL %s done_latency: got %0d expected %0d", name, done_cyc, fixed_done);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (obs_rd_cyc.size() != total) begin
            failures++;
            $display("FAIL %s rd_beats: got %0d expected %0d", name, obs_rd_cyc.size(), total);
        end
        checks++;
        if (obs_mac_cyc.size() != total) begin
            failures++;
            $display("FAIL %s mac_beats: got %0d expected %0d", name, obs_mac_cyc.size(), total);
        end
        for (int n = 0; n < total; n++) begin
            if (n < obs_rd_cyc.size()) begin
                checks += 3;
                if (obs_rd_cyc[n] != exp_iss[n] + 1) begin
                    failures++;
                    $display("FAIL %s beat%0d rd_cycle: got %0d expected %0d", name, n, obs_rd_cyc[n], exp_iss[n] + 1);
                end
                if (obs_a[n] != exp_a[n]) begin
                    failures++;
                    $display("FAIL %s beat%0d a_addr: got %0d expected %0d", name, n, obs_a[n], exp_a[n]);
                end
                if (obs_b[n] != exp_b[n]) begin
                    failures++;
                    $display("FAIL %s beat%0d b_addr: got %0d expected %0d", name, n, obs_b[n], exp_b[n]);
                end
            end
            if (n < obs_mac_cyc.size()) begin
                checks += 4;
                if (obs_mac_cyc[n] != exp_iss[n] + 1 + RD_LAT) begin
                    failures++;
                    $display("FAIL %s beat%0d mac_cycle: got %0d expected %0d", name, n, obs_mac_cyc[n], exp_iss[n] + 1 + RD_LAT);
                end
                if (obs_clr[n] != exp_f[n]) begin
                    failures++;
                    $display("FAIL %s beat%0d mac_clr: got %0b expected %0b", name, n, obs_clr[n], exp_f[n]);
                end
                if (obs_wr[n] != exp_l[n]) begin
                    failures++;
                    $display("FAIL %s beat%0d c_wr: got %0b expected %0b", name, n, obs_wr[n], exp_l[n]);
                end
                if (obs_c[n] != exp_c[n]) begin
                    failures++;
                    $display("FAIL %s beat%0d c_addr: got %0d expected %0d", name, n, obs_c[n], exp_c[n]);
                end
            end
        end
        checks++;
        if (err_seen) begin
            failures++;
            $display("FAIL %s cfg_err: got 1 expected 0", name);
        end
        checks++;
        if (busy_gap) begin
            failures++;
            $display("FAIL %s busy_during_pass: got 0 expected 1", name);
        end
        checks++;
        if (post_bad) begin
            failures++;
            $display("FAIL %s idle_after_done: got activity expected none", name);
        end
        $display("test_pass %s: M=%0d N=%0d K=%0d mode=%0d beats=%0d done_cycle=%0d",
                 name, m_n, n_n, k_n, mode, obs_rd_cyc.size(), done_cyc);
    endtask

    task automatic test_reset_mid_issue();
        int  beats, cyc;
        bit  leak;
        m_max = AW'(1); n_max = AW'(3); k_max = AW'(1);
        start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        beats = 0; cyc = 0;
        while (cyc < 50) begin
            if (rd_en) beats++;
            if (beats == 5) break;
            tick();
            cyc++;
        end
        checks++;
        if (beats != 5) begin
            failures++;
            $display("FAIL reset_mid beat5_timeout: got %0d beats expected 5", beats);
        end
        RST = 1'b1;
        tick();
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_mid rd_en: got %b expected 0", rd_en); end
        if (mac_en !== 1'b0) begin failures++; $display("FAIL reset_mid mac_en: got %b expected 0", mac_en); end
        if (c_wr !== 1'b0) begin failures++; $display("FAIL reset_mid c_wr: got %b expected 0", c_wr); end
        RST  = 1'b0;
        leak = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (rd_en || mac_en || c_wr || busy || done) leak = 1'b1;
        end
        checks++;
        if (leak) begin
            failures++;
            $display("FAIL reset_mid leak: got activity after reset expected none");
        end
        en = 1'b0;
        $display("test_reset_mid_issue: beats_before_reset=%0d", beats);
    endtask

    task automatic test_bad_cfg();
        int tm [6];
        int tn [6];
        int tk [6];
        bit terr [6];
        tm   = '{0, 127, 0, 127, 6, 127};
        tn   = '{0, 0, 127, 63, 0, 0};
        tk   = '{5, 127, 63, 0, 0, 31};
        terr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 6; c++) begin
            m_max = AW'(tm[c]); n_max = AW'(tn[c]); k_max = AW'(tk[c]);
            start = 1'b1; en = 1'b0;
            tick();
            start = 1'b0;
            checks += 2;
            if (cfg_err !== terr[c]) begin
                failures++;
                $display("FAIL bad_cfg%0d cfg_err: got %b expected %b", c, cfg_err, terr[c]);
            end
            if (busy !== !terr[c]) begin
                failures++;
                $display("FAIL bad_cfg%0d busy: got %b expected %b", c, busy, !terr[c]);
            end
            tick();
            checks += 2;
            if (cfg_err !== 1'b0) begin
                failures++;
                $display("FAIL bad_cfg%0d cfg_err_pulse: got %b expected 0", c, cfg_err);
            end
            if (busy !== !terr[c]) begin
                failures++;
                $display("FAIL bad_cfg%0d busy_hold: got %b expected %b", c, busy, !terr[c]);
            end
            $display("test_bad_cfg case%0d: m=%0d n=%0d k=%0d expect_err=%0b", c, tm[c], tn[c], tk[c], terr[c]);
            if (!terr[c]) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                tick();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pass("nominal", 1, 2, 1, 0, -1, 1'b0, 20);
        test_pass("backpressure", 1, 2, 1, 1, -1, 1'b0, 36);
        test_pass("k1", 1, 1, 0, 0, -1, 1'b0, 8);
        test_pass("unit", 0, 0, 0, 0, -1, 1'b0, 5);
        test_reset_mid_issue();
        test_pass("after_reset", 1, 2, 1, 0, -1, 1'b0, 20);
        test_bad_cfg();
        test_pass("ignored_start", 1, 2, 1, 0, 6, 1'b1, 20);
        for (int r = 0; r < 6; r++)
            test_pass($sformatf("random%0d", r), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 2, -1, 1'b0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
